// File: rtl/decoder_onehot_scan.sv
// decoder_onehot_scan: N-to-2^N one-hot decoder with a registered output and two modes.
//   DIRECT - decodes a handshaked select value with one cycle of latency.
//   SCAN   - drives a rotating one-hot pattern that advances every SCAN_DIV cycles.
//
// Optional feature: define DECODER_SCAN_MASK_EN to add a scan_mask input. SCAN then visits only
// the set mask bits, searching circularly upward. An all-zero mask blanks the output.
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   en        block enable; 0 forces IDLE
//   mode      0 = DIRECT, 1 = SCAN; sampled every cycle
//   in_valid  DIRECT: a is valid
//   in_ready  DIRECT: block accepts a
//   a         DIRECT select value
//   scan_mask (DECODER_SCAN_MASK_EN only) indices eligible for scanning
//   y         registered one-hot output, or all zero
//   y_valid   y holds a decoded/scan pattern
//   idx       index of the active bit of y
//   wrap      one-cycle pulse when the scan wraps back to its first index
module decoder_onehot_scan #(
  parameter int unsigned N_SEL    = 3,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_SEL-1:0]      a,
`ifdef DECODER_SCAN_MASK_EN
  input  logic [2**N_SEL-1:0]   scan_mask,
`endif
  output logic [2**N_SEL-1:0]   y,
  output logic                  y_valid,
  output logic [N_SEL-1:0]      idx,
  output logic                  wrap
);

  localparam int unsigned OUT_W = 2**N_SEL;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] One = OUT_W'(1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDirect = 2'd1;
  localparam logic [1:0] StScan   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [N_SEL-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_q, div_d;

  // Scan sequencing: first index on SCAN entry, next index at terminal count, and whether any
  // index is eligible at all.
  logic [N_SEL-1:0] first_idx;
  logic [N_SEL-1:0] next_idx;
  logic             mask_any;

`ifdef DECODER_SCAN_MASK_EN
  logic [N_SEL-1:0] cand;

  always_comb begin
    mask_any  = |scan_mask;
    first_idx = idx_q;  // all-zero mask: idx holds
    for (int i = OUT_W - 1; i >= 0; i--) begin
      if (scan_mask[i]) first_idx = N_SEL'(i);
    end
    // Descending offset so the nearest set bit above idx_q wins; offset OUT_W is idx_q itself.
    next_idx = idx_q;
    cand     = '0;
    for (int k = OUT_W; k >= 1; k--) begin
      cand = idx_q + N_SEL'(k);
      if (scan_mask[cand]) next_idx = cand;
    end
  end
`else
  always_comb begin
    mask_any  = 1'b1;
    first_idx = '0;
    next_idx  = idx_q + 1'b1;
  end
`endif

  assign in_ready = (state_q == StDirect) & en & ~mode;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    idx_d     = idx_q;
    div_d     = div_q;
    wrap_d    = 1'b0;
    if (!en) begin
      state_d   = StIdle;
      y_d       = '0;
      y_valid_d = 1'b0;
      idx_d     = '0;
      div_d     = '0;
    end else if (!mode) begin
      state_d = StDirect;
      div_d   = '0;
      if (state_q != StDirect) begin
        // Fresh entry: blank until the first accept.
        y_d       = '0;
        y_valid_d = 1'b0;
        idx_d     = '0;
      end else if (in_valid && in_ready) begin
        y_d       = One << a;
        idx_d     = a;
        y_valid_d = 1'b1;
      end
    end else begin
      state_d = StScan;
      if (state_q != StScan) begin
        div_d     = '0;
        idx_d     = first_idx;
        y_d       = mask_any ? (One << first_idx) : '0;
        y_valid_d = mask_any;
      end else if (div_q == DivLast) begin
        div_d = '0;
        if (mask_any) begin
          idx_d     = next_idx;
          y_d       = One << next_idx;
          y_valid_d = 1'b1;
          // Moving to an index not above the current one means the scan went round.
          wrap_d    = (next_idx <= idx_q);
        end else begin
          y_d       = '0;
          y_valid_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      idx_q     <= '0;
      wrap_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      idx_q     <= idx_d;
      wrap_q    <= wrap_d;
      div_q     <= div_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign idx     = idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_onehot_scan.sv
// Bench for decoder_onehot_scan: directed steps followed by random traffic, all checked against
// a cycle-count reference model. A second instance (N_SEL=2, SCAN_DIV=1) covers the fast scan.
module tb_decoder_onehot_scan;

  localparam int Div = 4;
  localparam int Ow  = 8;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid;
  logic [2:0] a;
  logic       in_ready, y_valid, wrap;
  logic [7:0] y;
  logic [2:0] idx;

  logic       en2, mode2, in_valid2, in_ready2, y_valid2, wrap2;
  logic [1:0] a2, idx2;
  logic [3:0] y2;
`ifdef DECODER_SCAN_MASK_EN
  logic [7:0] scan_mask;
  logic [3:0] scan_mask2;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 direct, 2 scan; m_t counts edges since SCAN entry.
  int m_st = 0;
  int m_t = 0;
  bit m_have = 0;
  int m_a = 0;

  always #5 clk = ~clk;

  decoder_onehot_scan #(.N_SEL(3), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .a(a),
`ifdef DECODER_SCAN_MASK_EN
    .scan_mask(scan_mask),
`endif
    .y(y), .y_valid(y_valid), .idx(idx), .wrap(wrap)
  );

  decoder_onehot_scan #(.N_SEL(2), .SCAN_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .in_valid(in_valid2),
    .in_ready(in_ready2), .a(a2),
`ifdef DECODER_SCAN_MASK_EN
    .scan_mask(scan_mask2),
`endif
    .y(y2), .y_valid(y_valid2), .idx(idx2), .wrap(wrap2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check in_ready, clock once, advance the model, then check the registered outputs.
  task automatic cycle();
    bit acc;
    int ei, ey, ev, ew;
    #1;
    chk("in_ready", in_ready, (m_st == 1 && en && !mode) ? 1 : 0);
    acc = (m_st == 1) && en && !mode && in_valid;
    @(posedge clk);
    if (!en) m_st = 0;
    else if (!mode) begin
      if (m_st != 1) begin m_st = 1; m_have = 0; end
      else if (acc) begin m_have = 1; m_a = int'(a); end
    end else begin
      if (m_st != 2) begin m_st = 2; m_t = 0; end
      else m_t++;
    end
    #1;
    ei = 0; ey = 0; ev = 0; ew = 0;
    if (m_st == 1 && m_have) begin ei = m_a; ey = 1 << m_a; ev = 1; end
    if (m_st == 2) begin
      ei = (m_t / Div) % Ow;
      ey = 1 << ei;
      ev = 1;
      ew = (m_t > 0 && m_t % (Div * Ow) == 0) ? 1 : 0;
    end
    chk("y", y, ey);
    chk("y_valid", y_valid, ev);
    chk("idx", idx, ei);
    chk("wrap", wrap, ew);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; a = '0;
    en2 = 1'b0; mode2 = 1'b1; in_valid2 = 1'b0; a2 = '0;
`ifdef DECODER_SCAN_MASK_EN
    scan_mask = 8'hff; scan_mask2 = 4'hf;
`endif
    // Reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_idx", idx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // DIRECT: entry, single accept, hold, back-to-back.
    en = 1'b1; mode = 1'b0;
    cycle();
    in_valid = 1'b1; a = 3'd5;
    cycle();
    chk("direct_a5_y", y, 8'h20);
    chk("direct_a5_idx", idx, 5);
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("direct_hold_y", y, 8'h20);
    in_valid = 1'b1; a = 3'd0;
    cycle();
    chk("direct_a0_y", y, 8'h01);
    a = 3'd7;
    cycle();
    chk("direct_a7_y", y, 8'h80);
    in_valid = 1'b0;

    // SCAN from DIRECT: one full 32-cycle period and the wrap pulse.
    mode = 1'b1;
    cycle();
    chk("scan_first_y", y, 8'h01);
    for (int t = 1; t <= 32; t++) begin
      cycle();
      if (t == 4) chk("scan_step1_y", y, 8'h02);
      if (t == 28) chk("scan_last_y", y, 8'h80);
      if (t == 32) chk("scan_wrap_pulse", wrap, 1);
    end
    cycle();
    chk("scan_wrap_single", wrap, 0);

    // Abandon the scan mid-step at idx=3, then disable.
    repeat (12) cycle();
    chk("mid_step_idx", idx, 3);
    mode = 1'b0;
    cycle();
    chk("abandon_y", y, 0);
    chk("abandon_wrap", wrap, 0);
    cycle();
    en = 1'b0;
    cycle();
    chk("idle_idx", idx, 0);

    // SCAN_DIV=1, N_SEL=2 instance.
    en2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("fast_y", y2, 1 << (i % 4));
      chk("fast_idx", idx2, i % 4);
      chk("fast_wrap", wrap2, (i > 0 && i % 4 == 0) ? 1 : 0);
      chk("fast_y_valid", y_valid2, 1);
    end
    en2 = 1'b0;

    // Asynchronous reset mid-scan with no clock edge.
    en = 1'b1; mode = 1'b1;
    repeat (6) cycle();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 0);
    chk("async_rst_y_valid", y_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_wrap", wrap, 0);
    chk("async_rst_idx", idx, 0);
    m_st = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic with sticky mode so scans run long enough to wrap.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 23) == 0) mode = ~mode;
      en = ($urandom_range(0, 29) != 0);
      in_valid = 1'($urandom_range(0, 1));
      a = 3'($urandom);
      cycle();
    end

`ifdef DECODER_SCAN_MASK_EN
    en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    scan_mask = 8'b1001_0100;
    @(posedge clk);
    #1 mode = 1'b1;
    @(posedge clk);
    #1 chk("mask_y0", y, 8'h04);
    repeat (4) @(posedge clk);
    #1 chk("mask_y1", y, 8'h10);
    repeat (4) @(posedge clk);
    #1 chk("mask_y2", y, 8'h80);
    repeat (4) @(posedge clk);
    #1 chk("mask_y3", y, 8'h04);
    chk("mask_wrap", wrap, 1);
    scan_mask = 8'h00;
    repeat (4) @(posedge clk);
    #1 chk("mask_zero_y", y, 0);
    chk("mask_zero_y_valid", y_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
